// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the register file with busy scoreboard:
// default geometry, port-slice packing helpers and the reset-value rule.
package regfile_scoreboard_pkg;

   localparam int DEFAULT_ADDR_W = 5;
   localparam int DEPTH          = 2 ** DEFAULT_ADDR_W;

   // Low bit of port `port` inside a bus that packs `width`-bit fields.
   function automatic int slice_lo(input int port, input int width);
      return port * width;
   endfunction

   // Value register `index` takes at reset. The caller truncates it to DATA_W.
   function automatic logic [63:0] reset_value(input int index, input bit reset_index);
      return reset_index ? 64'(index) : 64'd0;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard. A claim at issue sets a bit and a write-back
// clears it; a claim wins over a same-cycle write to the same register.
// claim_conflict flags a claim whose target was already busy.
module rf_scoreboard
   import regfile_scoreboard_pkg::*;
#(
   parameter int ADDR_W   = DEFAULT_ADDR_W,
   parameter int ZERO_REG = 1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 claim_en,
   input  logic [ADDR_W-1:0]    claim_addr,
   input  logic                 wr_en,
   input  logic [ADDR_W-1:0]    wr_addr,
   output logic [2**ADDR_W-1:0] busy_vec,
   output logic [2**ADDR_W-1:0] busy_next,
   output logic                 claim_conflict
);

   logic conflict_next;

   // Next scoreboard: release first, then claim, so a same-cycle claim wins.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      busy_next = busy_vec;
      if (wr_en)    busy_next[wr_addr]    = 1'b0;
      if (claim_en) busy_next[claim_addr] = 1'b1;
      if (ZERO_REG != 0) busy_next[0] = 1'b0;

      conflict_next = claim_en && busy_vec[claim_addr]
                      && !(wr_en && (wr_addr == claim_addr))
                      && !((ZERO_REG != 0) && (claim_addr == '0));
   end

   // Scoreboard and conflict pulse registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy_vec       <= '0;
         claim_conflict <= 1'b0;
      end else begin
         busy_vec       <= busy_next;
         claim_conflict <= conflict_next;
      end
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with NUM_RD registered read ports, write-first bypass,
// optional hardwired zero register and a busy scoreboard for RAW detection.
module regfile_scoreboard
   import regfile_scoreboard_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = DEFAULT_ADDR_W,
   parameter int NUM_RD      = 2,
   parameter int ZERO_REG    = 1,
   parameter int RESET_INDEX = 1
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     claim_en,
   input  logic [ADDR_W-1:0]        claim_addr,
   output logic                     claim_conflict,
   output logic [2**ADDR_W-1:0]     busy_vec
);

   localparam int NUM_REGS = 2 ** ADDR_W;

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [ADDR_W-1:0]   port_addr [NUM_RD];
   logic [NUM_REGS-1:0] busy_next;
   logic                wr_fire;

   // A write to register 0 is dropped when it is hardwired to zero.
   assign wr_fire = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

   // Unpack the per-port read addresses.
   always_comb begin
      for (int p = 0; p < NUM_RD; p++) begin
         port_addr[p] = rd_addr[slice_lo(p, ADDR_W) +: ADDR_W];
      end
   end

   rf_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clock          (clock),
      .reset_n        (reset_n),
      .claim_en       (claim_en),
      .claim_addr     (claim_addr),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .busy_vec       (busy_vec),
      .busy_next      (busy_next),
      .claim_conflict (claim_conflict)
   );

   // Storage array: loaded with its index (or zero) at reset, written on write-back.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the array is reset on purpose so software sees known initial
         // contents; this rules out a RAM macro and builds the array from flops.
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= DATA_W'(reset_value(i, RESET_INDEX != 0));
         end
      end else if (wr_fire) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Read ports: registered data with write-first bypass, plus post-update busy flag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_data <= '0;
         rd_busy <= '0;
      end else begin
         for (int p = 0; p < NUM_RD; p++) begin
            if (rd_en[p]) begin
               rd_data[slice_lo(p, DATA_W) +: DATA_W] <=
                  (wr_fire && (wr_addr == port_addr[p])) ? wr_data : regs[port_addr[p]];
               rd_busy[p] <= busy_next[port_addr[p]];
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard (default parameters: 32x32,
// two read ports, zero register, index reset). Directed table, hand-written
// reset sequence, then random traffic against a behavioural model.
module tb_regfile_scoreboard;

   logic        clock;
   logic        reset_n;
   logic [1:0]  rd_en;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        claim_en;
   logic [4:0]  claim_addr;
   logic        claim_conflict;
   logic [31:0] busy_vec;

   int tests_run = 0;
   int tests_failed = 0;

   regfile_scoreboard dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .rd_en          (rd_en),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .rd_busy        (rd_busy),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .claim_en       (claim_en),
      .claim_addr     (claim_addr),
      .claim_conflict (claim_conflict),
      .busy_vec       (busy_vec)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [1:0]  rd_en;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic        wr_en;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        ce;
      logic [4:0]  ca;
   } in_t;

   typedef struct {
      in_t         in;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  rb;
      logic        conf;
      logic [31:0] bv;
   } vec_t;

   // Behavioural model: architectural state plus expected output registers.
   logic [31:0] m_mem [32];
   bit          m_busy [32];
   logic [31:0] e_d [2];
   logic [1:0]  e_rb;
   logic        e_conf;

   function automatic in_t mk_in(input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
                                 input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic ce, input logic [4:0] ca);
      in_t v;
      v.rd_en = re; v.a0 = a0; v.a1 = a1;
      v.wr_en = we; v.wa = wa; v.wd = wd;
      v.ce = ce; v.ca = ca;
      return v;
   endfunction

   function automatic vec_t mk_vec(input in_t in, input logic [31:0] d0, input logic [31:0] d1,
                                   input logic [1:0] rb, input logic conf, input logic [31:0] bv);
      vec_t v;
      v.in = in; v.d0 = d0; v.d1 = d1; v.rb = rb; v.conf = conf; v.bv = bv;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_mem[i]  = 32'(i);
         m_busy[i] = 1'b0;
      end
      e_d[0] = '0; e_d[1] = '0; e_rb = '0; e_conf = 1'b0;
   endtask

   function automatic logic [31:0] model_bv();
      logic [31:0] b;
      for (int i = 0; i < 32; i++) b[i] = m_busy[i];
      return b;
   endfunction

   // One clock edge of the architecture: conflict judged on the old scoreboard,
   // then state updates, then reads observe the updated state (write-first).
   task automatic model_tick(input in_t v);
      logic [4:0] a [2];
      a[0] = v.a0; a[1] = v.a1;
      e_conf = v.ce && (v.ca != 0) && m_busy[v.ca] && !(v.wr_en && v.wa == v.ca);
      if (v.wr_en && v.wa != 0) m_mem[v.wa] = v.wd;
      if (v.wr_en) m_busy[v.wa] = 1'b0;
      if (v.ce)    m_busy[v.ca] = 1'b1;
      m_busy[0] = 1'b0;
      for (int p = 0; p < 2; p++) begin
         if (v.rd_en[p]) begin
            e_d[p]  = m_mem[a[p]];
            e_rb[p] = m_busy[a[p]];
         end
      end
   endtask

   task automatic drive(input in_t v);
      @(negedge clock);
      rd_en = v.rd_en; rd_addr = {v.a1, v.a0};
      wr_en = v.wr_en; wr_addr = v.wa; wr_data = v.wd;
      claim_en = v.ce; claim_addr = v.ca;
      @(posedge clock);
      model_tick(v);
      #1;
   endtask

   task automatic check_model(input string tag);
      check($sformatf("%s.d0", tag), {32'd0, rd_data[31:0]}, {32'd0, e_d[0]});
      check($sformatf("%s.d1", tag), {32'd0, rd_data[63:32]}, {32'd0, e_d[1]});
      check($sformatf("%s.rd_busy", tag), {62'd0, rd_busy}, {62'd0, e_rb});
      check($sformatf("%s.conflict", tag), {63'd0, claim_conflict}, {63'd0, e_conf});
      check($sformatf("%s.busy_vec", tag), {32'd0, busy_vec}, {32'd0, model_bv()});
   endtask

   vec_t vecs [12];

   initial begin
      in_t idle;
      in_t r;

      idle = mk_in(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

      //                     rd_en  a0     a1     we    wa     wd             ce    ca       d0             d1             rb     cf    bv
      vecs[0]  = mk_vec(mk_in(2'b11, 5'd7,  5'd31, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0),  32'd7,         32'd31,        2'b00, 1'b0, 32'h0);
      vecs[1]  = mk_vec(mk_in(2'b11, 5'd5,  5'd5,  1'b1, 5'd5,  32'hDEADBEEF,  1'b0, 5'd0),  32'hDEADBEEF,  32'hDEADBEEF,  2'b00, 1'b0, 32'h0);
      vecs[2]  = mk_vec(mk_in(2'b01, 5'd5,  5'd0,  1'b0, 5'd0,  32'h0,         1'b0, 5'd0),  32'hDEADBEEF,  32'hDEADBEEF,  2'b00, 1'b0, 32'h0);
      vecs[3]  = mk_vec(mk_in(2'b11, 5'd0,  5'd0,  1'b1, 5'd0,  32'h1234,      1'b1, 5'd0),  32'd0,         32'd0,         2'b00, 1'b0, 32'h0);
      vecs[4]  = mk_vec(mk_in(2'b00, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,         1'b1, 5'd9),  32'd0,         32'd0,         2'b00, 1'b0, 32'h200);
      vecs[5]  = mk_vec(mk_in(2'b01, 5'd9,  5'd0,  1'b0, 5'd0,  32'h0,         1'b1, 5'd9),  32'd9,         32'd0,         2'b01, 1'b1, 32'h200);
      vecs[6]  = mk_vec(idle,                                                                 32'd9,         32'd0,         2'b01, 1'b0, 32'h200);
      vecs[7]  = mk_vec(mk_in(2'b10, 5'd0,  5'd9,  1'b1, 5'd9,  32'h99,        1'b0, 5'd0),  32'd9,         32'h99,        2'b01, 1'b0, 32'h0);
      vecs[8]  = mk_vec(mk_in(2'b00, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,         1'b1, 5'd3),  32'd9,         32'h99,        2'b01, 1'b0, 32'h8);
      vecs[9]  = mk_vec(mk_in(2'b11, 5'd3,  5'd3,  1'b1, 5'd3,  32'h33,        1'b1, 5'd3),  32'h33,        32'h33,        2'b11, 1'b0, 32'h8);
      vecs[10] = mk_vec(mk_in(2'b01, 5'd3,  5'd0,  1'b0, 5'd0,  32'h0,         1'b0, 5'd0),  32'h33,        32'h33,        2'b11, 1'b0, 32'h8);
      vecs[11] = mk_vec(mk_in(2'b00, 5'd0,  5'd0,  1'b1, 5'd3,  32'h44,        1'b0, 5'd0),  32'h33,        32'h33,        2'b11, 1'b0, 32'h0);

      // Reset state.
      reset_n = 1'b0;
      rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      claim_en = 1'b0; claim_addr = '0;
      model_reset();
      #3;
      check("reset.rd_data", rd_data, 64'd0);
      check("reset.rd_busy", {62'd0, rd_busy}, 64'd0);
      check("reset.conflict", {63'd0, claim_conflict}, 64'd0);
      check("reset.busy_vec", {32'd0, busy_vec}, 64'd0);
      #9 reset_n = 1'b1;

      // Directed table.
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].in);
         check($sformatf("vec%0d.d0", i), {32'd0, rd_data[31:0]}, {32'd0, vecs[i].d0});
         check($sformatf("vec%0d.d1", i), {32'd0, rd_data[63:32]}, {32'd0, vecs[i].d1});
         check($sformatf("vec%0d.rd_busy", i), {62'd0, rd_busy}, {62'd0, vecs[i].rb});
         check($sformatf("vec%0d.conflict", i), {63'd0, claim_conflict}, {63'd0, vecs[i].conf});
         check($sformatf("vec%0d.busy_vec", i), {32'd0, busy_vec}, {32'd0, vecs[i].bv});
      end

      // Asynchronous reset while r12 is busy and a read is pending.
      drive(mk_in(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12));
      check("areset.pre_busy_vec", {32'd0, busy_vec}, 64'h1000);
      check("areset.pre_rd_data", rd_data, {32'h33, 32'h33});
      @(negedge clock);
      rd_en = 2'b11; rd_addr = {5'd12, 5'd12};
      #2 reset_n = 1'b0;
      #1;
      check("areset.rd_data", rd_data, 64'd0);
      check("areset.rd_busy", {62'd0, rd_busy}, 64'd0);
      check("areset.busy_vec", {32'd0, busy_vec}, 64'd0);
      check("areset.conflict", {63'd0, claim_conflict}, 64'd0);
      model_reset();
      @(negedge clock);
      rd_en = '0; claim_en = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      drive(mk_in(2'b11, 5'd12, 5'd12, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0));
      check("areset.post_d0", {32'd0, rd_data[31:0]}, 64'd12);
      check("areset.post_d1", {32'd0, rd_data[63:32]}, 64'd12);
      check("areset.post_rd_busy", {62'd0, rd_busy}, 64'd0);
      check_model("areset.post");

      // Random traffic on a narrow address range to force collisions.
      for (int n = 0; n < 400; n++) begin
         r.rd_en = 2'($urandom_range(0, 3));
         r.a0    = 5'($urandom_range(0, 7));
         r.a1    = 5'($urandom_range(0, 7));
         r.wr_en = ($urandom_range(0, 1) == 1);
         r.wa    = 5'($urandom_range(0, 7));
         r.wd    = $urandom;
         r.ce    = ($urandom_range(0, 9) < 4);
         r.ca    = ($urandom_range(0, 4) == 0) ? r.wa : 5'($urandom_range(0, 7));
         drive(r);
         check_model($sformatf("rand%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised successor to the processor's 32×32 register file, adding N synchronous read ports with write-to-read bypass, an optional hardwired-zero register, asynchronous reset, and a per-register busy scoreboard. The multicycle control unit claims a destination at issue and releases it on write-back, and reads the busy flags to detect RAW hazards. The block sits between instruction decode (read and claim addresses) and write-back (write port).

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, address width; depth is 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never busy
- RESET_INDEX, 1, when 1, reset loads register i with i (truncated to DATA_W); when 0, reset loads 0

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- rd_en  in  NUM_RD  per-port read strobe
- rd_addr  in  NUM_RD*ADDR_W  port p address in bits [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data, packed the same way as rd_addr
- rd_busy  out  NUM_RD  registered busy flag of the addressed register
- wr_en  in  1  write strobe (write-back)
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- claim_en  in  1  mark a destination busy (issue)
- claim_addr  in  ADDR_W  claimed register
- claim_conflict  out  1  one-cycle pulse: the claim targeted a register that was already busy
- busy_vec  out  2**ADDR_W  current scoreboard, one bit per register

## Operation
- **Reset (asynchronous, while reset_n=0):**
  - registers take their reset value (index or 0, per RESET_INDEX);
  - rd_data=0, rd_busy=0, claim_conflict=0, busy_vec=0.
- **Write:** on a clock edge with wr_en=1, the register at wr_addr takes wr_data, unless ZERO_REG=1 and wr_addr=0, in which case the write is dropped.
- **Read, port p:** on a clock edge with rd_en[p]=1:
  - rd_data[p] takes the register at rd_addr[p];
  - if wr_en=1 and wr_addr=rd_addr[p] (and the write is not dropped), rd_data[p] takes wr_data instead (write-first bypass);
  - when rd_en[p]=0, rd_data[p] and rd_busy[p] hold their values.
- **Scoreboard:**
  - claim sets busy[claim_addr]; wr_en clears busy[wr_addr];
  - claim and write to the same address in the same cycle: the claim wins and busy ends at 1 (a new producer has issued);
  - with ZERO_REG=1, busy[0] is forced to 0 and claims of register 0 never raise a conflict.
- **Conflict:** claim_conflict is registered. It is 1 in the cycle after a claim whose target was busy before this edge and is not being cleared by a same-cycle write. Otherwise it is 0.
- **rd_busy[p]:** reflects the scoreboard after this edge's update, so a same-cycle write clears it and a same-cycle claim sets it.
- **Out of range:** none; all addresses are in range by construction.

## Timing
- Read latency is 1 cycle, with data and busy flag valid in the cycle after rd_en. Throughput is one read per port per cycle.
- A write is visible to a plain read issued 1 cycle later, and to a read issued in the same cycle through the bypass.
- A claim is visible on busy_vec and rd_busy 1 cycle later.
- Reset mid-operation discards in-flight reads and all claims. The first valid read is at the first rising edge after reset_n rises.

## Structure
- The shared package holds:
  - localparam DEPTH = 2**ADDR_W;
  - the packing helper functions for port slices;
  - the RESET_INDEX init function.
- One sub-module, `rf_scoreboard`, holds the busy bits, the claim/release priority and claim_conflict. The top module holds the storage array and the read ports.

## Test plan
- **Reset values:** reset with RESET_INDEX=1, then read r7 on port 0 and r31 on port 1 → rd_data = 7 and 31 one cycle later; busy_vec=0.
- **Bypass:** write r5=0xDEADBEEF with a same-cycle read of r5 on both ports → both ports return 0xDEADBEEF next cycle. Plain read of r5 one cycle later → 0xDEADBEEF.
- **Zero register:** with ZERO_REG=1, write r0=0x1234 and claim r0 → a read of r0 returns 0; busy_vec[0]=0; no claim_conflict.
- **Scoreboard sequence:**
  - claim r9 → busy_vec[9]=1 next cycle;
  - re-claim r9 → claim_conflict pulses for exactly one cycle;
  - write r9 → busy_vec[9]=0.
- **Claim and write, same register, same cycle:** with r3 busy, assert claim r3 and write r3 together → busy stays 1, no conflict, r3 takes the new data.
- **Asynchronous reset mid-stream:** assert reset_n=0 between edges while r12 is busy and a read is pending → outputs and busy_vec go to 0 immediately without a clock edge; r12 reads 12 after release.
